// File: rtl/fpu_arb_pkg.sv
// ---------------------------------------------------------------------------
// fpu_arb_pkg
// Shared types and constants for the FPU arbiter slice.
//   state_t     : arbiter FSM states (IDLE, GRANT, LOAD, WAIT, RESP)
//   FP_W        : operand / result width
//   STATUS_W    : FPU status width (opaque to the arbiter)
//   EXP_W, MAN_W, EXP_BIAS : operand format (1 sign, 6-bit exponent with
//                bias 31, 25-bit mantissa); the arbiter never decodes it.
// ---------------------------------------------------------------------------
package fpu_arb_pkg;

    localparam int FP_W     = 32;
    localparam int STATUS_W = 4;

    localparam int EXP_W    = 6;
    localparam int MAN_W    = 25;
    localparam int EXP_BIAS = 31;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational request picker. Default build: round-robin, searching from
// i_rr_ptr upwards and wrapping. With FPU_ARB_FIXED_PRIO_EN defined the
// lowest requesting index always wins and i_rr_ptr is ignored.
// Ports:
//   i_req_valid  [NUM_REQ-1:0] : request vector
//   i_rr_ptr     [IDX_W-1:0]   : first index to consider
//   o_grant      [NUM_REQ-1:0] : one-hot winner (all zero if no request)
//   o_grant_idx  [IDX_W-1:0]   : binary index of the winner
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic             w_found;
    int               w_c_int;
    logic [IDX_W-1:0] w_c;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_c_int     = 0;
        w_c         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FPU_ARB_FIXED_PRIO_EN
            w_c_int = i;
`else
            // Candidate index for search step i, wrapped modulo NUM_REQ so
            // non-power-of-two requester counts work too.
            w_c_int = int'(i_rr_ptr) + i;
            if (w_c_int >= NUM_REQ) begin
                w_c_int = w_c_int - NUM_REQ;
            end
`endif
            w_c = IDX_W'(w_c_int);
            if (!w_found && i_req_valid[w_c]) begin
                w_found      = 1'b1;
                o_grant[w_c] = 1'b1;
                o_grant_idx  = w_c;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_arbiter
// Shares one multi-cycle FPU adder among NUM_REQ requesters. One operation
// at a time: IDLE -> GRANT -> LOAD -> WAIT (FPU_LATENCY cycles) -> RESP.
// LOAD pulses the FPU reset pin low for one cycle to restart it on the
// latched operands; the result is captured in the last WAIT cycle.
// Build option: FPU_ARB_FIXED_PRIO_EN selects fixed (lowest index) priority
// instead of round-robin.
//
// Handshake: a requester raises req_valid with its operands and holds them
// until req_ready[i] pulses (one cycle, in GRANT). Requests seen while busy
// are ignored. The result comes back as a one-cycle rsp_valid[i] strobe with
// no backpressure; rsp_data/rsp_status hold until the next response.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   req_valid/op_a/op_b     : requester side inputs (operands packed 32b/req)
//   req_ready, rsp_valid    : one-hot accept / result strobes
//   rsp_data, rsp_status    : captured FPU result and status
//   busy                    : high whenever not IDLE
//   fpu_reset_n             : FPU reset pin (active low)
//   fpu_op_a, fpu_op_b      : FPU operand inputs
//   fpu_data, fpu_status    : FPU outputs
//   dbg_state               : current FSM state
// ---------------------------------------------------------------------------
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FPU_LATENCY = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*FP_W-1:0] req_op_a,
    input  logic [NUM_REQ*FP_W-1:0] req_op_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]         rsp_data,
    output logic [STATUS_W-1:0]     rsp_status,
    output logic                    busy,
    output logic                    fpu_reset_n,
    output logic [FP_W-1:0]         fpu_op_a,
    output logic [FP_W-1:0]         fpu_op_b,
    input  logic [FP_W-1:0]         fpu_data,
    input  logic [STATUS_W-1:0]     fpu_status,
    output state_t                  dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FPU_LATENCY + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_winner;
    logic [NUM_REQ-1:0]  r_grant_oh;
    logic [FP_W-1:0]     r_op_a;
    logic [FP_W-1:0]     r_op_b;
    logic [FP_W-1:0]     r_rsp_data;
    logic [STATUS_W-1:0] r_rsp_status;
    logic                r_fpu_reset_n;

    logic [NUM_REQ-1:0]  w_arb_grant;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_req_any;
    logic                w_cnt_last;
    logic [FP_W-1:0]     w_sel_a;
    logic [FP_W-1:0]     w_sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx)
    );

    assign w_req_any  = |req_valid;
    assign w_cnt_last = (r_cnt == CNT_W'(FPU_LATENCY - 1));

    // Operand mux for the latched winner; constant slices per index.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_winner == IDX_W'(i)) begin
                w_sel_a = req_op_a[i*FP_W +: FP_W];
                w_sel_b = req_op_b[i*FP_W +: FP_W];
            end
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE:    if (w_req_any) w_state_nxt = GRANT;
            GRANT: begin
                w_state_nxt = LOAD;
                req_ready   = r_grant_oh;
            end
            LOAD:    w_state_nxt = WAIT;
            WAIT:    if (w_cnt_last) w_state_nxt = RESP;
            RESP: begin
                w_state_nxt = IDLE;
                rsp_valid   = r_grant_oh;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_rr_ptr      <= '0;
            r_winner      <= '0;
            r_grant_oh    <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_rsp_data    <= '0;
            r_rsp_status  <= '0;
            r_fpu_reset_n <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Registered from next-state so the pin is glitch-free and low
            // exactly for the LOAD cycle.
            r_fpu_reset_n <= (w_state_nxt != LOAD);

            // The winner is picked from the requests seen in IDLE and held
            // through the whole operation; requesters keep their operands
            // stable until req_ready, so GRANT can latch them.
            if (r_state == IDLE && w_req_any) begin
                r_winner   <= w_arb_idx;
                r_grant_oh <= w_arb_grant;
`ifndef FPU_ARB_FIXED_PRIO_EN
                r_rr_ptr   <= (w_arb_idx == IDX_W'(NUM_REQ - 1)) ?
                              '0 : w_arb_idx + IDX_W'(1);
`endif
            end

            if (r_state == GRANT) begin
                r_op_a <= w_sel_a;
                r_op_b <= w_sel_b;
            end

            if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            if (r_state == WAIT && w_cnt_last) begin
                r_rsp_data   <= fpu_data;
                r_rsp_status <= fpu_status;
            end
        end
    end

    assign rsp_data    = r_rsp_data;
    assign rsp_status  = r_rsp_status;
    assign fpu_op_a    = r_op_a;
    assign fpu_op_b    = r_op_b;
    assign fpu_reset_n = r_fpu_reset_n;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fpu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_arbiter
// Self-checking bench for fpu_arbiter (NUM_REQ=4, FPU_LATENCY=8) with a
// behavioural FPU adder that only produces a valid sum FPU_LATENCY-1 cycles
// after its reset is released.
// ---------------------------------------------------------------------------
module tb_fpu_arbiter;
    import fpu_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int LAT     = 8;
    localparam int W       = 56;

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic [3:0]  exp_status;
    } vec_t;

    logic                    clock;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*32-1:0]   req_op_a;
    logic [NUM_REQ*32-1:0]   req_op_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [31:0]             rsp_data;
    logic [3:0]              rsp_status;
    logic                    busy;
    logic                    fpu_reset_n;
    logic [31:0]             fpu_op_a;
    logic [31:0]             fpu_op_b;
    logic [31:0]             fpu_data;
    logic [3:0]              fpu_status;
    state_t                  dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          fpu_cnt  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_exp;
    logic [31:0] fpu_sum;
    vec_t        vecs[5];

    fpu_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .FPU_LATENCY (LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .busy        (busy),
        .fpu_reset_n (fpu_reset_n),
        .fpu_op_a    (fpu_op_a),
        .fpu_op_b    (fpu_op_b),
        .fpu_data    (fpu_data),
        .fpu_status  (fpu_status),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- FPU model ----------------
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic [26:0] ma, mb, mr;
        logic [5:0]  er;
        int          d;
        if (x[30:0] < y[30:0]) begin a = y; b = x; end
        else begin a = x; b = y; end
        ma = {2'b01, a[24:0]};
        mb = {2'b01, b[24:0]};
        d  = int'(a[30:25]) - int'(b[30:25]);
        mb = (d > 26) ? 27'd0 : (mb >> d);
        mr = (a[31] == b[31]) ? (ma + mb) : (ma - mb);
        er = a[30:25];
        if (mr == 27'd0) return 32'h0;
        if (mr[26]) begin
            mr = mr >> 1;
            er = er + 6'd1;
        end
        for (int k = 0; k < 26; k++) begin
            if (!mr[25]) begin
                mr = mr << 1;
                er = er - 6'd1;
            end
        end
        return {a[31], er, mr[24:0]};
    endfunction

    always @(posedge clock) begin
        if (!fpu_reset_n) fpu_cnt <= 0;
        else if (fpu_cnt < 1000) fpu_cnt <= fpu_cnt + 1;
    end
    assign fpu_sum    = fp_add(fpu_op_a, fpu_op_b);
    assign fpu_data   = (fpu_cnt >= LAT - 1) ? fpu_sum : 32'hDEADBEEF;
    assign fpu_status = (fpu_cnt >= LAT - 1) ? fpu_sum[31:28] : 4'hF;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input vec_t v, input int t);
        logic [3:0] oh;
        oh = 4'd1 << v.req;
        exp_q.push_back({16'(t + 2 + LAT), oh, v.exp_data, v.exp_status});
    endtask

    // Every response must match the oldest expectation: cycle, one-hot,
    // data and status.
    always @(negedge clock) begin
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: actual rsp_valid %b, required none (cycle %0d)",
                         rsp_valid, cyc);
            end else begin
                m_exp = exp_q.pop_front();
                check("rsp", {8'd0, 16'(cyc), rsp_valid, rsp_data, rsp_status}, {8'd0, m_exp});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input vec_t v);
        req_valid[v.req]           = 1'b1;
        req_op_a[32*v.req +: 32]   = v.a;
        req_op_b[32*v.req +: 32]   = v.b;
    endtask

    task automatic wait_grant(output logic [3:0] g, output int t);
        g = '0;
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (req_ready != '0) begin
                g = req_ready;
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: no req_ready within 60 cycles, required a grant");
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 100) begin
            @(negedge clock);
            i++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},       64'(dbg_state),   64'(IDLE));
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_req_ready"},   64'(req_ready),   64'd0);
        check({tag, "_rsp_valid"},   64'(rsp_valid),   64'd0);
        check({tag, "_rsp_data"},    64'(rsp_data),    64'd0);
        check({tag, "_rsp_status"},  64'(rsp_status),  64'd0);
        check({tag, "_fpu_op_a"},    64'(fpu_op_a),    64'd0);
        check({tag, "_fpu_op_b"},    64'(fpu_op_b),    64'd0);
        check({tag, "_fpu_reset_n"}, 64'(fpu_reset_n), 64'd0);
    endtask

    // Single request: grant, LOAD pulse, operands, response via scoreboard.
    task automatic run_vec(input vec_t v);
        logic [3:0] g;
        int         t;
        @(posedge clock); #1;
        set_req(v);
        wait_grant(g, t);
        check("vec_grant", 64'(g), 64'(4'd1 << v.req));
        push_exp(v, t);
        @(posedge clock); #1;
        req_valid = '0;
        @(negedge clock);
        check("vec_load_rstn", 64'(fpu_reset_n), 64'd0);
        check("vec_op_a", 64'(fpu_op_a), 64'(v.a));
        check("vec_op_b", 64'(fpu_op_b), 64'(v.b));
        @(negedge clock);
        check("vec_wait_rstn", 64'(fpu_reset_n), 64'd1);
        drain();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0] g;
        int         t, t0, tprev, seen;

        reset     = 1'b1;
        req_valid = '0;
        req_op_a  = '0;
        req_op_b  = '0;

        vecs[0] = '{0, 32'hBE000000, 32'hBE000000, 32'hC0000000, 4'hC}; // -1 + -1
        vecs[1] = '{1, 32'h3F000000, 32'h3C000000, 32'h40000000, 4'h4}; // 1.5 + 0.5
        vecs[2] = '{2, 32'h3E000000, 32'h3E000000, 32'h40000000, 4'h4}; // 1 + 1
        vecs[3] = '{3, 32'h3F000000, 32'hBC000000, 32'h3E000000, 4'h3}; // 1.5 - 0.5
        vecs[4] = '{2, 32'h40000000, 32'hC0000000, 32'h00000000, 4'h0}; // 2 - 2

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("por");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rstn_release", 64'(fpu_reset_n), 64'd1);

        // Table-driven single transactions.
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

`ifndef FPU_ARB_FIXED_PRIO_EN
        // All requesters valid from reset release: strict rotation 0,1,2,3,0.
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_req(vecs[i]);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        tprev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, t);
            check("rr_grant", 64'(g), 64'(4'd1 << (k % 4)));
            if (k > 0) check("rr_spacing", 64'(t - tprev), 64'd12);
            push_exp(vecs[k % 4], t);
            tprev = t;
        end
        @(posedge clock); #1;
        req_valid = '0;
        drain();
`else
        // Fixed priority: requesters 0 and 2 both valid, 0 wins every time.
        @(posedge clock); #1;
        set_req(vecs[0]);
        set_req(vecs[2]);
        tprev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_grant(g, t);
            check("fp_grant", 64'(g), 64'd1);
            if (k > 0) check("fp_spacing", 64'(t - tprev), 64'd12);
            push_exp(vecs[0], t);
            tprev = t;
        end
        @(posedge clock); #1;
        req_valid = '0;
        drain();
`endif

        // req3 pulses once while busy: must never be granted.
        @(posedge clock); #1;
        set_req(vecs[0]);
        wait_grant(g, t0);
        check("pulse_first_grant", 64'(g), 64'd1);
        push_exp(vecs[0], t0);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (3) @(posedge clock);
        #1;
        set_req(vecs[3]);
        @(posedge clock); #1;
        req_valid = '0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (req_ready != '0) seen++;
        end
        check("pulse_no_grant", 64'(seen), 64'd0);
        drain();

        // req3 raises during busy and holds: granted at RESP+2.
        @(posedge clock); #1;
        set_req(vecs[0]);
        wait_grant(g, t0);
        check("hold_first_grant", 64'(g), 64'd1);
        push_exp(vecs[0], t0);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (4) @(posedge clock);
        #1;
        set_req(vecs[3]);
        wait_grant(g, t);
        check("hold_grant", 64'(g), 64'b1000);
        check("hold_grant_cycle", 64'(t - t0), 64'(LAT + 4));
        push_exp(vecs[3], t);
        @(posedge clock); #1;
        req_valid = '0;
        drain();

        // Reset mid-WAIT: everything returns to reset values, no response.
        @(posedge clock); #1;
        set_req(vecs[2]);
        wait_grant(g, t);
        check("abort_grant", 64'(g), 64'b0100);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("abort_in_wait", 64'(dbg_state), 64'(WAIT));
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_reset_vals("mid");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("mid_rstn_release", 64'(fpu_reset_n), 64'd1);
        check("mid_idle", 64'(busy), 64'd0);
        repeat (20) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares one multi-cycle FPU adder among `NUM_REQ` requesters. Grants one request at a time, round-robin, and latches its operands. It then restarts the FPU with a one-cycle active-low pulse on the FPU's reset pin, waits a fixed `FPU_LATENCY`, and returns `data_out`/`status_out` to the granted requester. The block sits between the requester-side logic and the existing FPU instance, whose ports are `clock`, `reset`, `op_A_in`, `op_B_in`, `data_out` and `status_out`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `FPU_LATENCY`, default 8: cycles from FPU restart release to a valid result, ≥1.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester request. Held with operands until accepted.
- `req_op_a` in NUM_REQ*32: packed operand A; requester i uses bits [32i+31:32i].
- `req_op_b` in NUM_REQ*32: packed operand B, same layout.
- `req_ready` out NUM_REQ: one-hot accept pulse.
- `rsp_valid` out NUM_REQ: one-hot one-cycle result strobe.
- `rsp_data` out 32: result; held until the next response.
- `rsp_status` out 4: FPU status, opaque pass-through; held with `rsp_data`.
- `busy` out 1: high in every state except IDLE.
- `fpu_reset_n` out 1: drives the FPU `reset` pin, active-low.
- `fpu_op_a` out 32: drives FPU `op_A_in`.
- `fpu_op_b` out 32: drives FPU `op_B_in`.
- `fpu_data` in 32: from FPU `data_out`.
- `fpu_status` in 4: from FPU `status_out`.

## Operation
- States:
  - IDLE → GRANT when any `req_valid`.
  - GRANT → LOAD.
  - LOAD → WAIT.
  - WAIT → RESP when `cnt == FPU_LATENCY-1`.
  - RESP → IDLE.
- GRANT:
  - Arbiter picks the winner. `req_ready[winner]` is high for this cycle only.
  - Operands are latched into `fpu_op_a`/`fpu_op_b`; the winner index is latched.
- Round-robin: search starts at `rr_ptr`, lowest index at or after the pointer wins, wrapping. After a grant, `rr_ptr = winner+1`, with `NUM_REQ-1` wrapping to 0.
- LOAD: `fpu_reset_n = 0` for exactly one cycle. It is 1 in all other non-reset states.
- WAIT: `cnt` counts 0..`FPU_LATENCY-1`. In the cycle `cnt == FPU_LATENCY-1`, `fpu_data`/`fpu_status` are registered into `rsp_data`/`rsp_status`.
- RESP: `rsp_valid[winner] = 1` for one cycle. There is no backpressure; requesters must sample in that cycle.
- Operand outputs hold from GRANT+1 through RESP. They keep their last value in IDLE.
- A request dropping `req_valid` before grant has no effect. `req_valid` sampled during a busy operation is ignored until the block returns to IDLE.
- The arbiter does not interpret the operand format: 1 sign, 6-bit exponent (bias 31), 25-bit mantissa.

## Timing
- Accept at cycle t (GRANT). LOAD is at t+1, WAIT spans t+2..t+1+`FPU_LATENCY`, and `rsp_valid` is high at t+2+`FPU_LATENCY`.
- Throughput: one operation per `FPU_LATENCY`+4 cycles, counting IDLE. The earliest next GRANT is RESP+2.
- `reset` high forces the following at the next edge, regardless of state:
  - state IDLE, `cnt` 0, `rr_ptr` 0;
  - `req_ready` 0, `rsp_valid` 0, `busy` 0;
  - `rsp_data` 0, `rsp_status` 0, `fpu_op_a` 0, `fpu_op_b` 0;
  - `fpu_reset_n` 0.
- Reset mid-operation discards the operation with no response. `fpu_reset_n` returns to 1 in the first cycle after `reset` deasserts.
- Simultaneous `req_valid` from all requesters are served in strict rotation starting from `rr_ptr`.

## Configuration
- `FPU_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins; `rr_ptr` is neither maintained nor used.
- `FPU_ARB_FIXED_PRIO_EN` undefined (default): round-robin as specified above.

## Structure
- Package `fpu_arb_pkg` holds:
  - the state enum (IDLE, GRANT, LOAD, WAIT, RESP);
  - `FP_W = 32`, `STATUS_W = 4`;
  - the format constants `EXP_W = 6`, `MAN_W = 25`, `EXP_BIAS = 31`.
- Sub-module `rr_arbiter`: combinational grant from `req_valid` and `rr_ptr`, producing a one-hot grant and its index. The `FPU_ARB_FIXED_PRIO_EN` selection lives inside it.
- The top level holds the FSM, counter, operand and response registers, and the FPU-side drive.

## Test plan
- Single request, `FPU_LATENCY`=8: req0 sends 0xBE000000 + 0xBE000000 (-1.0 + -1.0).
  - `req_ready[0]` pulses at t.
  - `fpu_reset_n` is low at t+1.
  - `rsp_valid[0]` is high at t+10 with `rsp_data` = 0xC0000000 (-2.0).
- All 4 requesters valid continuously from reset release:
  - grants go 0,1,2,3,0;
  - each `rsp_valid` one-hot matches its grant;
  - responses are 12 cycles apart.
- req1 sends 0x3F000000 + 0x3C000000 (1.5 + 0.5) → `rsp_data` 0x40000000 (2.0) at `rsp_valid[1]`. The `rsp_status` value matches the FPU's `status_out`.
- `reset` asserted mid-WAIT:
  - the next cycle shows IDLE, `busy` 0, all outputs at reset values, `fpu_reset_n` 0;
  - no `rsp_valid` appears for the aborted operation.
- With `FPU_ARB_FIXED_PRIO_EN`, requesters 0 and 2 continuously valid: requester 0 wins every grant.
- req3 pulses `req_valid` for 1 cycle while the block is busy: no grant. It holds valid afterwards and is granted at RESP+2.
